serial_sub16: RTL and testbench
===============================

# serial_sub16

Bit-serial 16-bit subtractor computing Z = X − Y one bit per clock, LSB first, with the same flag set as the combinational ALU adder (S, ZR, CY, P, V). It is the area-minimal counterpart of the parallel adder: same operand and flag interface, the inverse operation, and a start/done handshake. Flags follow the ALU conventions so downstream logic can consume either block interchangeably.

## Interface
- WIDTH, 16, operand and result width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE or DONE.
- X  input  WIDTH  minuend. Sampled on the accepting edge.
- Y  input  WIDTH  subtrahend. Sampled on the accepting edge.
- busy  output  1  high while the subtraction is in progress.
- done  output  1  one-cycle pulse; Z and flags are valid from this cycle on.
- Z  output  WIDTH  difference X − Y, modulo 2^WIDTH.
- S  output  1  sign flag, Z[WIDTH-1].
- ZR  output  1  zero flag, Z == 0.
- CY  output  1  borrow: 1 when X < Y unsigned.
- P  output  1  even parity: 1 when Z has an even number of ones (~^Z).
- V  output  1  signed overflow: (X[MSB] != Y[MSB]) && (Z[MSB] != X[MSB]).

## Operation
- Method: Z = X + ~Y + 1 via a 1-bit full adder with a carry register. The carry initialises to 1 on accept. CY = ~final carry-out.
- States:
  - IDLE: busy=0, done=0, outputs hold last result. start=1 → latch X, Y into shift registers; set carry=1, count=0; go to RUN.
  - RUN: busy=1. Each edge:
    - sum bit = x[0] ^ ~y[0] ^ carry, shifted into the result MSB;
    - X/Y registers shift right;
    - carry updated, count incremented.
    - On the edge that processes bit WIDTH-1, go to DONE.
  - DONE: busy=0, done=1. Z and all flags are registered and stable.
    - start=1 → accept new operands exactly as from IDLE (go to RUN).
    - start=0 → go to IDLE.
- Operand MSBs are captured at accept for V; S/ZR/P are derived from the final Z.
- start during RUN is ignored. X/Y changes after the accepting edge have no effect.
- Z and flags update only on entry to DONE. Between results they hold their previous values, including through RUN.
- rst in any state, including mid-RUN:
  - go to IDLE;
  - busy=0, done=0;
  - Z=0, S=0, ZR=0, CY=0, P=0, V=0;
  - in-flight result discarded.
  - rst has priority over start.

## Timing
- Reset values: busy=0, done=0, Z=0, all flags 0, state IDLE, count=0.
- Accepting edge k (start=1 sampled in IDLE/DONE):
  - busy=1 after edge k;
  - bits computed on edges k+1 … k+WIDTH;
  - done=1 and busy=0 after edge k+WIDTH.
- Latency: WIDTH cycles from accepting edge to done. Back-to-back throughput: one result per WIDTH cycles.
- done is high for exactly one cycle unless start is held high, which makes DONE last one cycle before RUN re-entry.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then X=16'h8fff, Y=16'h8000, start 1 cycle → done 16 cycles later, Z=16'h0fff, S=0, ZR=0, CY=0, P=1, V=0; busy high exactly 16 cycles.
- X=16'hfffe, Y=16'h0002 → Z=16'hfffc, S=1, ZR=0, CY=0, P=1, V=0.
- Borrow and overflow cases:
  - X=16'h0002, Y=16'h0003 → Z=16'hffff, S=1, CY=1, P=1, V=0.
  - X=16'h8000, Y=16'h0001 → Z=16'h7fff, S=0, CY=0, P=0, V=1.
- X=16'haaaa, Y=16'haaaa with start held high through DONE → Z=0, ZR=1, P=1, CY=0, V=0. A second run starts immediately with no IDLE cycle; start pulses during RUN do not restart the count.
- Reset mid-operation: start with X=16'h1234, Y=16'h0001, assert rst at cycle 8 of RUN → next cycle busy=0, done=0, Z=0, all flags 0. No done pulse follows. A subsequent start completes normally with Z=16'h1233.

Source files
------------

// File: rtl/serial_sub16.sv
// Bit-serial subtractor: Z = X - Y one bit per clock, LSB first, via X + ~Y + 1.
// Flags follow the parallel ALU adder so either block can feed the same consumer.
//
// state | meaning
// IDLE  | waiting for start, last result held
// RUN   | one difference bit per edge, LSB first
// DONE  | one-cycle result pulse; start re-enters RUN directly
module serial_sub16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Z,
  output logic             S,
  output logic             ZR,
  output logic             CY,
  output logic             P,
  output logic             V
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] x_sh, y_sh, acc, acc_nx;
  logic [CW-1:0]    count;
  logic             carry, carry_nx, sum_bit;
  logic             x_msb, y_msb;
  logic             accept, last_bit;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last_bit = 1'b0;
    sum_bit  = x_sh[0] ^ ~y_sh[0] ^ carry;
    carry_nx = (x_sh[0] & ~y_sh[0]) | (carry & (x_sh[0] ^ ~y_sh[0]));
    acc_nx   = {sum_bit, acc[WIDTH-1:1]};
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (count == CW'(WIDTH - 1)) begin
          last_bit = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x_sh  <= '0;
      y_sh  <= '0;
      acc   <= '0;
      count <= '0;
      carry <= 1'b0;
      x_msb <= 1'b0;
      y_msb <= 1'b0;
      Z     <= '0;
      S     <= 1'b0;
      ZR    <= 1'b0;
      CY    <= 1'b0;
      P     <= 1'b0;
      V     <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        x_sh  <= X;
        y_sh  <= Y;
        carry <= 1'b1;
        count <= '0;
        x_msb <= X[WIDTH-1];
        y_msb <= Y[WIDTH-1];
      end else if (state == RUN) begin
        x_sh  <= x_sh >> 1;
        y_sh  <= y_sh >> 1;
        carry <= carry_nx;
        count <= count + 1'b1;
        acc   <= acc_nx;
      end
      // Published results change only on entry to DONE
      if (last_bit) begin
        Z  <= acc_nx;
        S  <= acc_nx[WIDTH-1];
        ZR <= (acc_nx == '0);
        CY <= ~carry_nx;
        P  <= ~^acc_nx;
        V  <= (x_msb != y_msb) && (acc_nx[WIDTH-1] != x_msb);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_sub16.sv
// Randomised bench for serial_sub16 against an arithmetic reference model,
// plus directed cases with hand-computed results.
module tb_serial_sub16;

  localparam int W = 16;

  logic         clk, rst, start;
  logic [W-1:0] X, Y, Z;
  logic         busy, done, S, ZR, CY, P, V;

  int total = 0;
  int bad   = 0;

  serial_sub16 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y),
    .busy(busy), .done(done), .Z(Z),
    .S(S), .ZR(ZR), .CY(CY), .P(P), .V(V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation in flight is a countdown of remaining cycles;
  // the result is computed once from the operands with plain arithmetic.
  int           remaining = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_z = '0;
  logic         m_s = 1'b0, m_zr = 1'b0, m_cy = 1'b0, m_p = 1'b0, m_v = 1'b0;
  logic [W-1:0] p_z;
  logic         p_s, p_zr, p_cy, p_p, p_v;

  always @(posedge clk) begin
    int diff;
    if (rst) begin
      remaining = 0;
      m_done = 1'b0;
      m_z = '0;
      {m_s, m_zr, m_cy, m_p, m_v} = 5'b0;
    end else begin
      m_done = 1'b0;
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          m_done = 1'b1;
          m_z = p_z;
          {m_s, m_zr, m_cy, m_p, m_v} = {p_s, p_zr, p_cy, p_p, p_v};
        end
      end else if (start) begin
        remaining = W;
        p_z  = X - Y;
        p_s  = p_z[W-1];
        p_zr = (p_z == 0);
        p_cy = (X < Y);
        p_p  = ($countones(p_z) % 2 == 0);
        diff = int'($signed(X)) - int'($signed(Y));
        p_v  = (diff > 32767) || (diff < -32768);
      end
    end
  end

  always @(negedge clk) begin
    chk("cycle_outputs",
        32'({busy, done, Z, S, ZR, CY, P, V}),
        32'({remaining > 0, m_done, m_z, m_s, m_zr, m_cy, m_p, m_v}));
  end

  task automatic wait_done(input string tag, output int bc);
    int cyc;
    cyc = 0;
    bc  = 0;
    while (!done && cyc < 40) begin
      if (busy) bc++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] ez, input logic [4:0] efl);
    int bc;
    start = 1'b1; X = x; Y = y;
    @(negedge clk);
    start = 1'b0; X = W'($urandom); Y = W'($urandom);
    wait_done(tag, bc);
    chk({tag, "_z"}, 32'(Z), 32'(ez));
    chk({tag, "_flags_s_zr_cy_p_v"}, 32'({S, ZR, CY, P, V}), 32'(efl));
    chk({tag, "_busy_cycles"}, 32'(bc), 32'(W));
    @(negedge clk);
  endtask

  initial begin
    int bc, dones;
    logic [W-1:0] corners [4];
    corners[0] = 16'h0000; corners[1] = 16'hffff;
    corners[2] = 16'h8000; corners[3] = 16'h7fff;

    rst = 1'b1; start = 1'b0; X = '0; Y = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'({busy, done, Z, S, ZR, CY, P, V}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    //                                 S ZR CY P V
    run_op("a", 16'h8fff, 16'h8000, 16'h0fff, 5'b0_0_0_1_0);
    run_op("b", 16'hfffe, 16'h0002, 16'hfffc, 5'b1_0_0_1_0);
    run_op("c", 16'h0002, 16'h0003, 16'hffff, 5'b1_0_1_1_0);
    run_op("d", 16'h8000, 16'h0001, 16'h7fff, 5'b0_0_0_0_1);

    // start held through DONE: the next run begins with no IDLE cycle
    start = 1'b1; X = 16'haaaa; Y = 16'haaaa;
    @(negedge clk);
    wait_done("held", bc);
    chk("held_z", 32'(Z), 32'h0);
    chk("held_flags_s_zr_cy_p_v", 32'({S, ZR, CY, P, V}), 32'(5'b0_1_0_1_0));
    @(negedge clk);
    chk("held_restart_busy", 32'(busy), 32'd1);
    X = W'($urandom); Y = W'($urandom);
    for (int i = 0; i < 12; i++) begin
      start = i[0];
      @(negedge clk);
    end
    start = 1'b0;
    wait_done("held2", bc);
    chk("held2_z", 32'(Z), 32'h0);
    @(negedge clk);

    // Reset mid-run discards the operation
    start = 1'b1; X = 16'h1234; Y = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_outputs", 32'({busy, done, Z, S, ZR, CY, P, V}), 32'd0);
    dones = 0;
    for (int i = 0; i < 24; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("midrst_no_done", 32'(dones), 32'd0);
    run_op("after_rst", 16'h1234, 16'h0001, 16'h1233, 5'b0_0_0_1_0);

    // Random traffic checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      X = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
      Y = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
